// File: rtl/st7789_pkg.sv
// ---------------------------------------------------------------------------
// st7789_pkg
// Shared definitions for the 240x240 ST7789 display path. Used by the
// rectangle-fill drawing stage and by the display refresh stage.
//   DISP_W / DISP_H : visible panel size in pixels
//   ADDR_W          : vmem address width, address = {y[7:0], x[7:0]}
//   rgb565_t        : 16-bit RGB565 pixel
//   state_e         : drawing-stage state (IDLE / FILL)
//   rect_t          : normalised, clipped rectangle bounds
// ---------------------------------------------------------------------------
package st7789_pkg;

    localparam int DISP_W = 240;
    localparam int DISP_H = 240;
    localparam int ADDR_W = 16;

    typedef logic [15:0] rgb565_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    typedef struct packed {
        logic [7:0] xs;
        logic [7:0] xe;
        logic [7:0] ys;
        logic [7:0] ye;
    } rect_t;

    // Unsigned 8-bit min / max used when normalising rectangle corners.
    function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a < b) ? b : a;
    endfunction

endpackage : st7789_pkg

// File: rtl/vmem_rect_fill_norm_clip.sv
// ---------------------------------------------------------------------------
// vmem_rect_fill_norm_clip
// Combinational corner normalisation, clipping and reject detection for a
// rectangle-fill command.
//   x0_i, y0_i, x1_i, y1_i : raw corners (any order)
//   rect_o                 : xs<=xe, ys<=ye, end coordinates clipped to W-1/H-1
//   reject_o               : start coordinate lies entirely off-screen
// ---------------------------------------------------------------------------
module vmem_rect_fill_norm_clip
    import st7789_pkg::*;
#(
    parameter int W = DISP_W,
    parameter int H = DISP_H
) (
    input  logic [7:0] x0_i,
    input  logic [7:0] y0_i,
    input  logic [7:0] x1_i,
    input  logic [7:0] y1_i,
    output rect_t      rect_o,
    output logic       reject_o
);

    localparam logic [7:0] X_MAX = 8'(W - 1);
    localparam logic [7:0] Y_MAX = 8'(H - 1);

    logic [7:0] xe_raw;
    logic [7:0] ye_raw;

    always_comb begin
        rect_o    = '0;
        xe_raw    = max8(x0_i, x1_i);
        ye_raw    = max8(y0_i, y1_i);
        rect_o.xs = min8(x0_i, x1_i);
        rect_o.ys = min8(y0_i, y1_i);
        rect_o.xe = (xe_raw > X_MAX) ? X_MAX : xe_raw;
        rect_o.ye = (ye_raw > Y_MAX) ? Y_MAX : ye_raw;
        // If the start is off-screen the clipped end would precede it, so
        // such a command has no visible pixels at all.
        reject_o  = (rect_o.xs > X_MAX) || (rect_o.ys > Y_MAX);
    end

endmodule : vmem_rect_fill_norm_clip

// File: rtl/vmem_rect_fill.sv
// ---------------------------------------------------------------------------
// vmem_rect_fill
// Rectangle-fill drawing stage. Accepts a fill command over valid/ready and
// writes the rectangle into video memory in raster order, one pixel per
// clock.
//   w_clk, w_rst_n          : clock, asynchronous active-low reset
//   w_cmd_valid/w_cmd_ready : command handshake (ready == idle)
//   w_x0..w_y1, w_color     : corners (any order) and RGB565 fill colour
//   w_abort                 : stop an in-progress fill (ignored when idle)
//   w_st_wadr/we/wdata      : vmem write port, address {y, x}
//   w_busy                  : fill in progress
//   w_done                  : one-cycle pulse after the last write
//   w_err                   : one-cycle pulse for a rejected command
// ---------------------------------------------------------------------------
module vmem_rect_fill
    import st7789_pkg::*;
#(
    parameter int W = DISP_W,
    parameter int H = DISP_H
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_cmd_valid,
    output logic              w_cmd_ready,
    input  logic [7:0]        w_x0,
    input  logic [7:0]        w_y0,
    input  logic [7:0]        w_x1,
    input  logic [7:0]        w_y1,
    input  logic [15:0]       w_color,
    input  logic              w_abort,
    output logic [ADDR_W-1:0] w_st_wadr,
    output logic              w_st_we,
    output logic [15:0]       w_st_wdata,
    output logic              w_busy,
    output logic              w_done,
    output logic              w_err
);

    rect_t   cmd_rect;
    logic    cmd_reject;

    state_e  state_q;
    logic [7:0] x_q;        // current pixel x, also the presented address
    logic [7:0] y_q;        // current pixel y
    logic [7:0] xs_q;       // row restart column
    logic [7:0] xe_q;       // last column
    logic [7:0] ye_q;       // last row
    rgb565_t color_q;
    logic    we_q;
    logic    done_q;
    logic    err_q;

    logic    accept;
    logic    last_px;

    vmem_rect_fill_norm_clip #(
        .W (W),
        .H (H)
    ) u_norm_clip (
        .x0_i     (w_x0),
        .y0_i     (w_y0),
        .x1_i     (w_x1),
        .y1_i     (w_y1),
        .rect_o   (cmd_rect),
        .reject_o (cmd_reject)
    );

    assign accept  = (state_q == IDLE) && w_cmd_valid;
    // The write currently on the port is the final {ye, xe} pixel.
    assign last_px = (x_q == xe_q) && (y_q == ye_q);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            xs_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            color_q <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    we_q <= 1'b0;
                    // Abort has no meaning here, even alongside an accept.
                    if (accept) begin
                        if (cmd_reject) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q <= FILL;
                            we_q    <= 1'b1;
                            x_q     <= cmd_rect.xs;
                            y_q     <= cmd_rect.ys;
                            xs_q    <= cmd_rect.xs;
                            xe_q    <= cmd_rect.xe;
                            ye_q    <= cmd_rect.ye;
                            color_q <= w_color;
                        end
                    end
                end
                FILL: begin
                    if (w_abort) begin
                        // The write presented this cycle stands; nothing after.
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                    end else if (last_px) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (x_q == xe_q) begin
                        // Equality wrap keeps 8-bit counters safe at 239/255.
                        x_q <= xs_q;
                        y_q <= y_q + 8'd1;
                    end else begin
                        x_q <= x_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign w_cmd_ready = (state_q == IDLE);
    assign w_busy      = (state_q == FILL);
    assign w_st_we     = we_q;
    assign w_st_wadr   = {y_q, x_q};
    assign w_st_wdata  = color_q;
    assign w_done      = done_q;
    assign w_err       = err_q;

endmodule : vmem_rect_fill

// File: tb/tb_vmem_rect_fill.sv
// ---------------------------------------------------------------------------
// tb_vmem_rect_fill
// Scoreboard bench for vmem_rect_fill. Each accepted command pushes its
// expected writes (with the sample cycle they must appear in), its expected
// done pulse or its expected err pulse; a negedge monitor pops and compares.
// Cycle numbering: cyc counts posedges; outputs following edge E are sampled
// at the negedge where cyc == E.
// ---------------------------------------------------------------------------
module tb_vmem_rect_fill;

    typedef struct {
        int          cyc;
        logic [15:0] adr;
        logic [15:0] dat;
    } wr_t;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_cmd_valid = 1'b0;
    logic        w_cmd_ready;
    logic [7:0]  w_x0 = '0, w_y0 = '0, w_x1 = '0, w_y1 = '0;
    logic [15:0] w_color = '0;
    logic        w_abort = 1'b0;
    logic [15:0] w_st_wadr;
    logic        w_st_we;
    logic [15:0] w_st_wdata;
    logic        w_busy;
    logic        w_done;
    logic        w_err;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    wr_t wq[$];
    int  done_q[$];
    int  err_q[$];

    vmem_rect_fill dut (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_cmd_valid (w_cmd_valid),
        .w_cmd_ready (w_cmd_ready),
        .w_x0        (w_x0),
        .w_y0        (w_y0),
        .w_x1        (w_x1),
        .w_y1        (w_y1),
        .w_color     (w_color),
        .w_abort     (w_abort),
        .w_st_wadr   (w_st_wadr),
        .w_st_we     (w_st_we),
        .w_st_wdata  (w_st_wdata),
        .w_busy      (w_busy),
        .w_done      (w_done),
        .w_err       (w_err)
    );

    always #5 w_clk = ~w_clk;
    always @(posedge w_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every write / done / err must match the head of its queue.
    always @(negedge w_clk) begin
        if (w_rst_n) begin
            if (w_st_we) begin
                if (wq.size() == 0) begin
                    check("extra_write", 32'(w_st_wadr), 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_cycle", 32'(cyc), 32'(e.cyc));
                    check("wr_adr", 32'(w_st_wadr), 32'(e.adr));
                    check("wr_dat", 32'(w_st_wdata), 32'(e.dat));
                    check("wr_busy", 32'(w_busy), 32'd1);
                end
            end
            if (w_done) begin
                if (done_q.size() == 0) check("extra_done", 32'(cyc), 32'hFFFF_FFFF);
                else check("done_cycle", 32'(cyc), 32'(done_q.pop_front()));
            end
            if (w_err) begin
                if (err_q.size() == 0) check("extra_err", 32'(cyc), 32'hFFFF_FFFF);
                else check("err_cycle", 32'(cyc), 32'(err_q.pop_front()));
            end
        end
    end

    // Reference model: pushes up to 'limit' writes, plus done when complete.
    task automatic push_model(input int k, input logic [7:0] x0, y0, x1, y1,
                              input logic [15:0] col, input int limit);
        int xs, xe, ys, ye, idx;
        xs = (x0 < x1) ? int'(x0) : int'(x1);
        xe = (x0 < x1) ? int'(x1) : int'(x0);
        ys = (y0 < y1) ? int'(y0) : int'(y1);
        ye = (y0 < y1) ? int'(y1) : int'(y0);
        if (xe > 239) xe = 239;
        if (ye > 239) ye = 239;
        if (xs > 239 || ys > 239) begin
            err_q.push_back(k);
            return;
        end
        idx = 0;
        for (int y = ys; y <= ye; y++) begin
            for (int x = xs; x <= xe; x++) begin
                if (idx < limit) begin
                    wr_t e;
                    e.cyc = k + idx;
                    e.adr = {8'(y), 8'(x)};
                    e.dat = col;
                    wq.push_back(e);
                end
                idx++;
            end
        end
        if (limit >= idx) done_q.push_back(k + idx);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input logic [7:0] x0, y0, x1, y1, input logic [15:0] col,
                         input int limit, input bit abort_too);
        int budget;
        budget = 0;
        w_x0 = x0; w_y0 = y0; w_x1 = x1; w_y1 = y1; w_color = col;
        w_cmd_valid = 1'b1;
        w_abort = abort_too;
        while (!w_cmd_ready && budget < 70000) begin
            @(negedge w_clk);
            budget++;
        end
        if (!w_cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            w_cmd_valid = 1'b0;
            w_abort = 1'b0;
            return;
        end
        push_model(cyc + 1, x0, y0, x1, y1, col, limit);
        @(negedge w_clk);
        w_cmd_valid = 1'b0;
        w_abort = 1'b0;
        // Scramble inputs: the command must already be captured.
        w_x0 = 8'($urandom); w_y0 = 8'($urandom);
        w_x1 = 8'($urandom); w_y1 = 8'($urandom);
        w_color = 16'($urandom);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((wq.size() != 0 || done_q.size() != 0 || err_q.size() != 0 || !w_cmd_ready)
               && budget < 70000) begin
            @(negedge w_clk);
            budget++;
        end
        @(negedge w_clk);
        if (budget >= 70000) begin
            check("drain_timeout", 32'd0, 32'd1);
            wq.delete(); done_q.delete(); err_q.delete();
        end
    endtask

    initial begin
        // Reset values
        #3;
        check("rst_we", 32'(w_st_we), 32'd0);
        check("rst_wadr", 32'(w_st_wadr), 32'd0);
        check("rst_wdata", 32'(w_st_wdata), 32'd0);
        check("rst_done", 32'(w_done), 32'd0);
        check("rst_err", 32'(w_err), 32'd0);
        check("rst_busy", 32'(w_busy), 32'd0);
        check("rst_ready", 32'(w_cmd_ready), 32'd1);
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;
        @(negedge w_clk);

        // Abort in idle has no effect
        w_abort = 1'b1;
        repeat (2) @(negedge w_clk);
        w_abort = 1'b0;
        check("idle_abort_ready", 32'(w_cmd_ready), 32'd1);

        // Single pixel, accepted with abort coinciding (abort ignored)
        issue(8'd5, 8'd7, 8'd5, 8'd7, 16'hF800, 1 << 30, 1'b1);
        $display("cmd single pixel accepted at cyc %0d", cyc);
        wait_idle();

        // Swapped corners: 22 writes
        issue(8'd20, 8'd11, 8'd10, 8'd10, 16'h07E0, 1 << 30, 1'b0);
        $display("cmd swapped corners accepted at cyc %0d", cyc);
        wait_idle();

        // Clip: 10 writes ending at {0,239}
        issue(8'd230, 8'd0, 8'd250, 8'd0, 16'h001F, 1 << 30, 1'b0);
        $display("cmd clip accepted at cyc %0d", cyc);
        wait_idle();

        // Reject: err pulse, no writes, ready stays high
        issue(8'd240, 8'd0, 8'd245, 8'd0, 16'hFFFF, 1 << 30, 1'b0);
        check("reject_ready", 32'(w_cmd_ready), 32'd1);
        check("reject_busy", 32'(w_busy), 32'd0);
        $display("cmd reject accepted at cyc %0d", cyc);
        wait_idle();

        // Bottom-right clip in y as well
        issue(8'd238, 8'd255, 8'd255, 8'd237, 16'h1234, 1 << 30, 1'b0);
        $display("cmd corner clip accepted at cyc %0d", cyc);
        wait_idle();

        // Full screen, second command held valid back-to-back
        issue(8'd0, 8'd0, 8'd239, 8'd239, 16'hA5A5, 1 << 30, 1'b0);
        $display("cmd full screen accepted at cyc %0d", cyc);
        issue(8'd3, 8'd2, 8'd1, 8'd2, 16'h5A5A, 1 << 30, 1'b0);
        $display("cmd back-to-back accepted at cyc %0d", cyc);
        wait_idle();

        // Abort during the 5th write of a 100-pixel fill
        issue(8'd20, 8'd30, 8'd29, 8'd39, 16'h0F0F, 5, 1'b0);
        $display("cmd abort fill accepted at cyc %0d", cyc);
        repeat (4) @(negedge w_clk);
        w_abort = 1'b1;
        @(negedge w_clk);
        w_abort = 1'b0;
        check("abort_we", 32'(w_st_we), 32'd0);
        check("abort_ready", 32'(w_cmd_ready), 32'd1);
        check("abort_busy", 32'(w_busy), 32'd0);
        repeat (3) @(negedge w_clk);
        wait_idle();

        // Reset mid-row
        issue(8'd0, 8'd100, 8'd199, 8'd101, 16'hCAFE, 1 << 30, 1'b0);
        $display("cmd reset-interrupted fill accepted at cyc %0d", cyc);
        repeat (10) @(negedge w_clk);
        #2 w_rst_n = 1'b0;
        #1;
        check("arst_we", 32'(w_st_we), 32'd0);
        check("arst_busy", 32'(w_busy), 32'd0);
        check("arst_ready", 32'(w_cmd_ready), 32'd1);
        wq.delete();
        done_q.delete();
        @(negedge w_clk);
        check("arst_wadr", 32'(w_st_wadr), 32'd0);
        check("arst_done", 32'(w_done), 32'd0);
        w_rst_n = 1'b1;
        @(negedge w_clk);
        issue(8'd50, 8'd60, 8'd52, 8'd61, 16'hBEEF, 1 << 30, 1'b0);
        $display("cmd post-reset accepted at cyc %0d", cyc);
        wait_idle();

        repeat (5) @(negedge w_clk);
        check("left_writes", 32'(wq.size()), 32'd0);
        check("left_done", 32'(done_q.size()), 32'd0);
        check("left_err", 32'(err_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vmem_rect_fill

// File: doc/vmem_rect_fill.md
Name: vmem_rect_fill

Overview:
- Upstream drawing stage for the 240x240 ST7789 display path.
- Accepts rectangle-fill commands through a valid/ready handshake and walks the rectangle in raster order.
- Drives the video-memory write port ({y,x} address, write enable, RGB565 data) that the display refresh stage reads from.
- Produces one pixel write per clock, with no stalls, because the vmem write port is always available.

Parameters:
- W, 240, visible width in pixels; x coordinates are clipped to W-1.
- H, 240, visible height in pixels; y coordinates are clipped to H-1.

Ports:
- w_clk  in  1  main clock (100MHz)
- w_rst_n  in  1  asynchronous active-low reset
- w_cmd_valid  in  1  command present
- w_cmd_ready  out  1  block is idle and will accept a command
- w_x0  in  8  corner A x
- w_y0  in  8  corner A y
- w_x1  in  8  corner B x
- w_y1  in  8  corner B y
- w_color  in  16  RGB565 fill colour
- w_abort  in  1  stop the current fill
- w_st_wadr  out  16  vmem write address {y[7:0], x[7:0]}
- w_st_we  out  1  vmem write enable
- w_st_wdata  out  16  vmem write data
- w_busy  out  1  fill in progress
- w_done  out  1  one-cycle pulse when a fill completes
- w_err  out  1  one-cycle pulse when a command is rejected

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset values: w_st_we=0, w_st_wadr=0, w_st_wdata=0, w_done=0, w_err=0, w_busy=0, w_cmd_ready=1. All outputs are registered.
- States: IDLE and FILL. w_cmd_ready=(state==IDLE). w_busy=(state==FILL).
- Accept: a command is accepted at the edge where w_cmd_valid && w_cmd_ready. Corner and colour fields are captured at that edge only; later changes on the inputs are ignored.
- Normalise: xs=min(x0,x1), xe=max(x0,x1); ys and ye likewise.
- Clip: xe=min(xe,W-1), ye=min(ye,H-1).
- Reject: if xs>W-1 or ys>H-1, pulse w_err in the cycle after accept, perform no writes, stay in IDLE (ready stays 1).
- Latency: for an accepted edge k, the first write (w_st_we=1, wadr={ys,xs}) appears in cycle k+1.
- Write stream: one write per cycle in raster order. x runs xs..xe; at xe, x wraps to xs and y increments.
- Write count: N=(xe-xs+1)*(ye-ys+1) consecutive w_st_we=1 cycles, ending with wadr={ye,xe}.
- Data: w_st_wdata holds the captured colour for the whole fill.
- Completion: in cycle k+N+1, w_st_we=0, w_done=1 for exactly one cycle, and the state returns to IDLE (ready=1).
- Back-to-back commands: a command held valid is accepted on that same k+N+1 edge. The next first write is then in cycle k+N+2, giving a one-cycle gap between fills.
- Abort: w_abort sampled high in FILL goes to IDLE next cycle. w_st_we=0 from that cycle on; no w_done. A write already presented on the sampling edge stands.
- Abort outside FILL: w_abort in IDLE has no effect. If w_abort coincides with an accept, the command is still accepted and abort is ignored.
- Reset mid-fill: w_st_we drops to 0 asynchronously. No w_done follows. The block restarts in IDLE.
- Width rules: counters are 8 bits. The x and y wrap comparisons use ==xe and ==ye, so there is no overflow at 239 or 255.
- Pixel count: N is never computed in hardware.

Decomposition:
- Shared package (st7789_pkg): constants DISP_W=240, DISP_H=240, ADDR_W=16; RGB565 colour typedef; state enum {IDLE, FILL}. The display refresh stage uses the same package.
- Sub-module: none required. Optionally split out rect_norm_clip (combinational min/max/clip/reject) for unit testing.

Test Plan:
- Single pixel: x0=x1=5, y0=y1=7, colour 16'hF800 -> exactly one write, wadr=16'h0705, then w_done one cycle later.
- Swapped corners: x0=20, y0=11, x1=10, y1=10 -> 22 writes, first {10,10}, last {11,20}. After {10,20} the next address is {11,10}.
- Clip and reject: x0=230, x1=250, y0=y1=0 -> 10 writes ending at {0,239}. Then x0=240, x1=245 -> w_err pulse, zero writes, ready stays 1.
- Full screen, back-to-back: (0,0)-(239,239) held valid with a second command queued -> 57600 writes, w_done at cycle k+57601, second fill's first write at k+57602.
- Abort: assert w_abort during the 5th write of a 100-pixel fill -> writes stop the next cycle, no w_done, ready=1.
- Reset mid-fill: drop w_rst_n mid-row -> w_st_we=0 immediately. After release, a new command produces its first write exactly one cycle after accept.
